// File: rtl/simmem_wresp_delay_unit.sv
// Write-response delay unit: reserves a slot per forwarded write address and
// releases each returned response oldest-first once its programmed delay has
// elapsed, never letting a response overtake an older one with the same ID.
module simmem_wresp_delay_unit #(
    parameter int unsigned NumSlots   = 8,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned DataWidth  = 2,
    parameter int unsigned DelayWidth = 6,
    parameter int unsigned CntWidth   = $clog2(NumSlots + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DelayWidth-1:0] delay_i,
    input  logic                  waddr_in_valid_i,
    output logic                  waddr_in_ready_o,
    input  logic [IdWidth-1:0]    waddr_id_i,
    output logic                  waddr_out_valid_o,
    input  logic                  waddr_out_ready_i,
    input  logic                  wresp_in_valid_i,
    output logic                  wresp_in_ready_o,
    input  logic [IdWidth-1:0]    wresp_in_id_i,
    input  logic [DataWidth-1:0]  wresp_in_data_i,
    output logic                  wresp_out_valid_o,
    input  logic                  wresp_out_ready_i,
    output logic [IdWidth-1:0]    wresp_out_id_o,
    output logic [DataWidth-1:0]  wresp_out_data_o,
    output logic [CntWidth-1:0]   occupancy_o
);

    localparam int unsigned IdxWidth = $clog2(NumSlots);

    // Slot storage; older_q[i][j] means slot i was accepted before slot j.
    logic [NumSlots-1:0]   occ_q, occ_d;
    logic [NumSlots-1:0]   has_rsp_q, has_rsp_d;
    logic [IdWidth-1:0]    id_q   [NumSlots];
    logic [IdWidth-1:0]    id_d   [NumSlots];
    logic [DelayWidth-1:0] cnt_q  [NumSlots];
    logic [DelayWidth-1:0] cnt_d  [NumSlots];
    logic [DataWidth-1:0]  data_q [NumSlots];
    logic [DataWidth-1:0]  data_d [NumSlots];
    logic [NumSlots-1:0]   older_q [NumSlots];
    logic [NumSlots-1:0]   older_d [NumSlots];
    logic                  lock_q, lock_d;
    logic [IdxWidth-1:0]   lock_idx_q, lock_idx_d;
    logic [CntWidth-1:0]   occ_cnt_q, occ_cnt_d;

    logic                  free;
    logic                  addr_hs;
    logic [IdxWidth-1:0]   alloc_idx;
    logic [NumSlots-1:0]   rsp_cand;
    logic [NumSlots-1:0]   rel_cand;
    logic                  rsp_hit;
    logic [IdxWidth-1:0]   rsp_idx;
    logic                  rel_hit;
    logic [IdxWidth-1:0]   rel_idx;
    logic                  out_valid;
    logic [IdxWidth-1:0]   out_idx;
    logic                  rsp_hs;
    logic                  out_hs;

    // Oldest slot among a candidate set: the one no other candidate precedes.
    function automatic logic [IdxWidth:0] oldest_of(input logic [NumSlots-1:0] cand);
        logic [IdxWidth:0] res;
        logic              blocked;
        res = '0;
        for (int i = 0; i < NumSlots; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < NumSlots; j++) begin
                if (cand[j] && older_q[j][i]) blocked = 1'b1;
            end
            if (cand[i] && !blocked) res = {1'b1, IdxWidth'(i)};
        end
        return res;
    endfunction

    // Lowest-index free slot, from registered occupancy only.
    always_comb begin
        alloc_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!occ_q[i]) alloc_idx = IdxWidth'(i);
        end
    end

    assign free              = ~&occ_q;
    assign waddr_in_ready_o  = free & waddr_out_ready_i;
    assign waddr_out_valid_o = free & waddr_in_valid_i;
    assign addr_hs           = free & waddr_in_valid_i & waddr_out_ready_i;

    // Response-match candidates and releasable slots (same-ID order respected).
    always_comb begin
        rsp_cand = '0;
        rel_cand = '0;
        for (int i = 0; i < NumSlots; i++) begin
            rsp_cand[i] = occ_q[i] & ~has_rsp_q[i] & (id_q[i] == wresp_in_id_i);
            rel_cand[i] = occ_q[i] & has_rsp_q[i] & (cnt_q[i] == '0);
            for (int j = 0; j < NumSlots; j++) begin
                if (occ_q[j] && older_q[j][i] && (id_q[j] == id_q[i])) rel_cand[i] = 1'b0;
            end
        end
    end

    assign {rsp_hit, rsp_idx} = oldest_of(rsp_cand);
    assign {rel_hit, rel_idx} = oldest_of(rel_cand);

    assign out_valid         = lock_q | rel_hit;
    assign out_idx           = lock_q ? lock_idx_q : rel_idx;
    assign wresp_out_valid_o = out_valid;
    assign wresp_out_id_o    = out_valid ? id_q[out_idx]   : '0;
    assign wresp_out_data_o  = out_valid ? data_q[out_idx] : '0;
    assign wresp_in_ready_o  = rsp_hit;
    assign occupancy_o       = occ_cnt_q;

    assign rsp_hs = wresp_in_valid_i & rsp_hit;
    assign out_hs = out_valid & wresp_out_ready_i;

    // Next-state: countdown, response capture, release, allocation.
    always_comb begin
        occ_d      = occ_q;
        has_rsp_d  = has_rsp_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        older_d    = older_q;
        occ_cnt_d  = occ_cnt_q;
        lock_d     = out_valid & ~wresp_out_ready_i;
        lock_idx_d = out_idx;

        for (int i = 0; i < NumSlots; i++) begin
            if (occ_q[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - DelayWidth'(1);
        end

        if (rsp_hs) begin
            has_rsp_d[rsp_idx] = 1'b1;
            data_d[rsp_idx]    = wresp_in_data_i;
        end

        if (out_hs) begin
            occ_d[out_idx]     = 1'b0;
            has_rsp_d[out_idx] = 1'b0;
        end

        if (addr_hs) begin
            occ_d[alloc_idx]     = 1'b1;
            has_rsp_d[alloc_idx] = 1'b0;
            id_d[alloc_idx]      = waddr_id_i;
            cnt_d[alloc_idx]     = delay_i;
            older_d[alloc_idx]   = '0;
            for (int j = 0; j < NumSlots; j++) begin
                if (IdxWidth'(j) != alloc_idx) older_d[j][alloc_idx] = 1'b1;
            end
        end

        if (addr_hs && !out_hs) begin
            occ_cnt_d = occ_cnt_q + CntWidth'(1);
        end else if (!addr_hs && out_hs) begin
            occ_cnt_d = occ_cnt_q - CntWidth'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q      <= '0;
            has_rsp_q  <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            occ_cnt_q  <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                id_q[i]    <= '0;
                cnt_q[i]   <= '0;
                data_q[i]  <= '0;
                older_q[i] <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            has_rsp_q  <= has_rsp_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            occ_cnt_q  <= occ_cnt_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            older_q    <= older_d;
        end
    end

endmodule

// File: tb/tb_simmem_wresp_delay_unit.sv
// Bench for simmem_wresp_delay_unit: directed traffic with a release-order scoreboard.
module tb_simmem_wresp_delay_unit;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] data;
    } rsp_t;

    logic       clk;
    logic       rst_ni;
    logic [5:0] delay_i;
    logic       waddr_in_valid_i;
    logic       waddr_in_ready_o;
    logic [3:0] waddr_id_i;
    logic       waddr_out_valid_o;
    logic       waddr_out_ready_i;
    logic       wresp_in_valid_i;
    logic       wresp_in_ready_o;
    logic [3:0] wresp_in_id_i;
    logic [1:0] wresp_in_data_i;
    logic       wresp_out_valid_o;
    logic       wresp_out_ready_i;
    logic [3:0] wresp_out_id_o;
    logic [1:0] wresp_out_data_o;
    logic [3:0] occupancy_o;

    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    rsp_t sb[$];
    int   rel_cycles[$];
    rsp_t mon_e;
    logic prev_stall = 1'b0;
    logic [3:0] prev_id = '0;
    logic [1:0] prev_data = '0;

    simmem_wresp_delay_unit dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .delay_i           (delay_i),
        .waddr_in_valid_i  (waddr_in_valid_i),
        .waddr_in_ready_o  (waddr_in_ready_o),
        .waddr_id_i        (waddr_id_i),
        .waddr_out_valid_o (waddr_out_valid_o),
        .waddr_out_ready_i (waddr_out_ready_i),
        .wresp_in_valid_i  (wresp_in_valid_i),
        .wresp_in_ready_o  (wresp_in_ready_o),
        .wresp_in_id_i     (wresp_in_id_i),
        .wresp_in_data_i   (wresp_in_data_i),
        .wresp_out_valid_o (wresp_out_valid_o),
        .wresp_out_ready_i (wresp_out_ready_i),
        .wresp_out_id_o    (wresp_out_id_o),
        .wresp_out_data_o  (wresp_out_data_o),
        .occupancy_o       (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: value of cyc between two rising edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_rsp(input logic [3:0] id, input logic [1:0] data);
        sb.push_back(rsp_t'({id, data}));
    endtask

    // Output monitor just before each rising edge: scoreboard pop and lock stability.
    always @(negedge clk) begin
        #4;
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("lock_valid", 32'(wresp_out_valid_o), 32'd1);
                check("lock_id",    32'(wresp_out_id_o),    32'(prev_id));
                check("lock_data",  32'(wresp_out_data_o),  32'(prev_data));
            end
            if (wresp_out_valid_o && wresp_out_ready_i) begin
                check("rsp_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rsp_id",   32'(wresp_out_id_o),   32'(mon_e.id));
                    check("rsp_data", 32'(wresp_out_data_o), 32'(mon_e.data));
                end
                rel_cycles.push_back(cyc);
            end
            prev_stall = wresp_out_valid_o & ~wresp_out_ready_i;
            prev_id    = wresp_out_id_o;
            prev_data  = wresp_out_data_o;
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting cycle.
    task automatic send_addr(input logic [3:0] id, input logic [5:0] d, output int acc);
        acc = -1;
        waddr_in_valid_i = 1'b1;
        waddr_id_i       = id;
        delay_i          = d;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (waddr_in_ready_o) begin
                acc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        waddr_in_valid_i = 1'b0;
        if (acc < 0) check("addr_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_rsp(input logic [3:0] id, input logic [1:0] data, output int acc);
        acc = -1;
        wresp_in_valid_i = 1'b1;
        wresp_in_id_i    = id;
        wresp_in_data_i  = data;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (wresp_in_ready_o) begin
                acc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        wresp_in_valid_i = 1'b0;
        if (acc < 0) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        waddr_in_valid_i = 1'b0;
        wresp_in_valid_i = 1'b0;
        wresp_out_ready_i = 1'b1;
        @(negedge clk);
        rst_ni = 1'b1;
        sb.delete();
        rel_cycles.delete();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int ta, tb, tr, tr2, e;

        rst_ni            = 1'b0;
        delay_i           = '0;
        waddr_in_valid_i  = 1'b1;
        waddr_id_i        = '0;
        waddr_out_ready_i = 1'b1;
        wresp_in_valid_i  = 1'b1;
        wresp_in_id_i     = 4'd3;
        wresp_in_data_i   = '0;
        wresp_out_ready_i = 1'b1;

        // Reset values.
        #2;
        check("rst_wresp_in_ready", 32'(wresp_in_ready_o), 32'd0);
        check("rst_out_valid", 32'(wresp_out_valid_o), 32'd0);
        check("rst_occupancy", 32'(occupancy_o), 32'd0);
        check("rst_out_id", 32'(wresp_out_id_o), 32'd0);
        check("rst_out_data", 32'(wresp_out_data_o), 32'd0);
        check("rst_waddr_in_ready_hi", 32'(waddr_in_ready_o), 32'd1);
        check("rst_waddr_out_valid_hi", 32'(waddr_out_valid_o), 32'd1);
        waddr_out_ready_i = 1'b0;
        waddr_in_valid_i  = 1'b0;
        #1;
        check("rst_waddr_in_ready_lo", 32'(waddr_in_ready_o), 32'd0);
        check("rst_waddr_out_valid_lo", 32'(waddr_out_valid_o), 32'd0);
        waddr_out_ready_i = 1'b1;
        wresp_in_valid_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // Single write: ID 3, delay 5, response two cycles after the address.
        rel_cycles.delete();
        send_addr(4'd3, 6'd5, ta);
        check("t1_occ_one", 32'(occupancy_o), 32'd1);
        @(negedge clk);
        expect_rsp(4'd3, 2'd2);
        send_rsp(4'd3, 2'd2, tr);
        wait_drain();
        e = ta + 6;
        if (tr + 1 > e) e = tr + 1;
        check("t1_release_cycle", 32'(rel_cycles.size() > 0 ? rel_cycles[0] : -1), 32'(e));
        check("t1_occ_zero", 32'(occupancy_o), 32'd0);

        // Fill all slots, ninth address blocked, then resume after one release.
        do_reset();
        for (int i = 0; i < 8; i++) send_addr(4'(i), 6'd0, ta);
        check("t2_occ_full", 32'(occupancy_o), 32'd8);
        waddr_in_valid_i = 1'b1;
        waddr_id_i       = 4'd9;
        #1;
        check("t2_full_in_ready", 32'(waddr_in_ready_o), 32'd0);
        check("t2_full_out_valid", 32'(waddr_out_valid_o), 32'd0);
        waddr_in_valid_i = 1'b0;
        expect_rsp(4'd2, 2'd3);
        send_rsp(4'd2, 2'd3, tr);
        send_addr(4'd9, 6'd0, ta);
        wait_drain();
        check("t2_release_cycle", 32'(rel_cycles.size() > 0 ? rel_cycles[0] : -1), 32'(tr + 1));
        check("t2_resume_cycle", 32'(ta), 32'(tr + 2));
        check("t2_occ_after", 32'(occupancy_o), 32'd8);

        // Same-ID ordering: long delay first, short delay second.
        do_reset();
        send_addr(4'd1, 6'd20, ta);
        send_addr(4'd1, 6'd2, tb);
        expect_rsp(4'd1, 2'd1);
        expect_rsp(4'd1, 2'd2);
        send_rsp(4'd1, 2'd1, tr);
        send_rsp(4'd1, 2'd2, tr2);
        wait_drain();
        check("t3_a_cycle", 32'(rel_cycles.size() > 0 ? rel_cycles[0] : -1), 32'(ta + 21));
        check("t3_b_after_a", 32'(rel_cycles.size() > 1 ? rel_cycles[1] : -1), 32'(ta + 22));

        // Cross-ID reorder: younger ID 2 with short delay overtakes ID 1.
        do_reset();
        send_addr(4'd1, 6'd30, ta);
        send_addr(4'd2, 6'd1, tb);
        expect_rsp(4'd2, 2'd0);
        expect_rsp(4'd1, 2'd3);
        send_rsp(4'd1, 2'd3, tr);
        send_rsp(4'd2, 2'd0, tr2);
        wait_drain();
        e = tb + 2;
        if (tr2 + 1 > e) e = tr2 + 1;
        check("t4_id2_cycle", 32'(rel_cycles.size() > 0 ? rel_cycles[0] : -1), 32'(e));
        check("t4_id1_cycle", 32'(rel_cycles.size() > 1 ? rel_cycles[1] : -1), 32'(ta + 31));

        // Stall and lock: younger presented while older becomes releasable.
        do_reset();
        wresp_out_ready_i = 1'b0;
        send_addr(4'd4, 6'd15, ta);
        send_addr(4'd5, 6'd0, tb);
        expect_rsp(4'd5, 2'd2);
        expect_rsp(4'd4, 2'd1);
        send_rsp(4'd4, 2'd1, tr);
        send_rsp(4'd5, 2'd2, tr2);
        for (int n = 0; n < 50; n++) begin
            #1;
            if (wresp_out_valid_o) break;
            @(negedge clk);
        end
        check("t5_first_valid", 32'(wresp_out_valid_o), 32'd1);
        repeat (22) @(negedge clk);
        #1;
        check("t5_locked_id", 32'(wresp_out_id_o), 32'd5);
        check("t5_locked_data", 32'(wresp_out_data_o), 32'd2);
        check("t5_no_release_yet", 32'(rel_cycles.size()), 32'd0);
        wresp_out_ready_i = 1'b1;
        wait_drain();
        check("t5_back_to_back", 32'(rel_cycles.size() > 1 ? rel_cycles[1] : -1),
              32'(rel_cycles.size() > 0 ? rel_cycles[0] + 1 : -2));

        // Unmatched response stalls until its address arrives; then reset mid-traffic.
        do_reset();
        wresp_in_valid_i = 1'b1;
        wresp_in_id_i    = 4'd7;
        wresp_in_data_i  = 2'd1;
        #1;
        check("t6_unmatched_ready", 32'(wresp_in_ready_o), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("t6_unmatched_still", 32'(wresp_in_ready_o), 32'd0);
        expect_rsp(4'd7, 2'd1);
        send_addr(4'd7, 6'd3, ta);
        #1;
        check("t6_rsp_ready_next", 32'(wresp_in_ready_o), 32'd1);
        check("t6_rsp_cycle", 32'(cyc), 32'(ta + 1));
        @(negedge clk);
        wresp_in_valid_i = 1'b0;
        send_addr(4'd6, 6'd10, tb);
        waddr_in_valid_i  = 1'b1;
        waddr_id_i        = 4'd5;
        wresp_in_valid_i  = 1'b1;
        wresp_in_id_i     = 4'd6;
        waddr_out_ready_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_rst_wresp_in_ready", 32'(wresp_in_ready_o), 32'd0);
        check("t6_rst_out_valid", 32'(wresp_out_valid_o), 32'd0);
        check("t6_rst_occupancy", 32'(occupancy_o), 32'd0);
        check("t6_rst_out_id", 32'(wresp_out_id_o), 32'd0);
        check("t6_rst_waddr_in_ready", 32'(waddr_in_ready_o), 32'd0);
        check("t6_rst_waddr_out_valid", 32'(waddr_out_valid_o), 32'd1);
        waddr_out_ready_i = 1'b1;
        #1;
        check("t6_rst_waddr_in_ready_follow", 32'(waddr_in_ready_o), 32'd1);
        waddr_in_valid_i = 1'b0;
        wresp_in_valid_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        sb.delete();
        rel_cycles.delete();
        repeat (40) @(negedge clk);
        #1;
        check("t6_post_rst_occ", 32'(occupancy_o), 32'd0);
        check("t6_post_rst_no_release", 32'(rel_cycles.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/simmem_wresp_delay_unit.md
# simmem_wresp_delay_unit

Parametrised write-response delay unit for the simulated memory controller. It sits between the requester and the real memory controller on the write-address and write-response channels. It reserves a response slot for every write address it forwards. It holds each returned write response until a per-request programmable delay has elapsed, then releases responses oldest-first while preserving AXI same-ID ordering.

## Interface
Parameters:
- NumSlots, 8, response slots (max outstanding writes), ≥2
- IdWidth, 4, AXI ID width
- DataWidth, 2, response payload width excluding ID (e.g. BRESP)
- DelayWidth, 6, delay counter width
- CntWidth, $clog2(NumSlots+1), occupancy width (derived)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous active-low reset
- delay_i  in  DelayWidth  delay in cycles, sampled on each accepted address
- waddr_in_valid_i  in  1  address valid from requester
- waddr_in_ready_o  out  1  address ready to requester
- waddr_id_i  in  IdWidth  address ID
- waddr_out_valid_o  out  1  address valid to real controller
- waddr_out_ready_i  in  1  address ready from real controller
- wresp_in_valid_i  in  1  response valid from real controller
- wresp_in_ready_o  out  1  response ready to real controller
- wresp_in_id_i  in  IdWidth  response ID
- wresp_in_data_i  in  DataWidth  response payload
- wresp_out_valid_o  out  1  delayed response valid to requester
- wresp_out_ready_i  in  1  requester ready
- wresp_out_id_o  out  IdWidth  delayed response ID
- wresp_out_data_o  out  DataWidth  delayed response payload
- occupancy_o  out  CntWidth  number of occupied slots

## Operation
- Per-slot state: occupied, id, counter, has_rsp, data, and acceptance age (relative order among occupied slots).
- free = at least one slot unoccupied (registered state only).
- waddr_in_ready_o = free & waddr_out_ready_i.
- waddr_out_valid_o = free & waddr_in_valid_i.
- Address handshake = free & waddr_in_valid_i & waddr_out_ready_i. The address payload passes through externally; this block sees only the ID.
- On address handshake: the lowest-index free slot becomes occupied, id = waddr_id_i, counter = delay_i, has_rsp = 0. The slot is marked youngest.
- Counter: decrements by 1 every cycle while occupied and nonzero, saturates at 0. It is independent of response arrival.
- Response match: target = the oldest occupied slot with id == wresp_in_id_i and has_rsp = 0.
- wresp_in_ready_o = a target exists. A response with no target stalls (ready low); it is never dropped.
- On response handshake: target.has_rsp = 1, target.data = wresp_in_data_i.
- Releasable slot: occupied & has_rsp & counter == 0 & no older occupied slot with the same id.
- Output selection: when no response is presented, the oldest releasable slot is selected. wresp_out_valid_o = a slot is selected. The ID and data are driven from that slot.
- Once presented, the selection is locked. Index, ID and data must not change until wresp_out_valid_o & wresp_out_ready_i, even if an older slot becomes releasable.
- On output handshake: the selected slot is freed and the lock is cleared.
- Simultaneous events in one cycle (address accept, response accept, output release) are all legal:
  - the freed slot is not reusable in the same cycle;
  - a response never matches a slot allocated in the same cycle.
- occupancy_o = registered count of occupied slots. It is incremented on address handshake, decremented on output handshake, and unchanged when both occur.
- Reset at any time clears all slots and the output lock. In-flight transactions are lost.
- Reset values:
  - wresp_in_ready_o = 0, wresp_out_valid_o = 0, occupancy_o = 0;
  - wresp_out_id_o and wresp_out_data_o = 0;
  - waddr_in_ready_o follows waddr_out_ready_i;
  - waddr_out_valid_o follows waddr_in_valid_i.

## Timing
- Address path is combinational: zero added latency.
- Address accepted in cycle t with delay D: counter = D in cycle t+1 and reaches 0 in cycle t+1+D.
- Response accepted in cycle r (r ≥ t+1): has_rsp is visible in cycle r+1.
- Earliest wresp_out_valid_o = max(t+1+D, r+1), assuming no older same-ID or older releasable slot blocks it.
- D = 0 with response at r = t+1: output valid at t+2.
- Full: with NumSlots occupied, waddr_in_ready_o = 0 and waddr_out_valid_o = 0. A slot freed by a handshake in cycle k allows acceptance in cycle k+1.
- Output valid holds until handshake (AXI stability).
- Back-to-back releases: one per cycle when ready is held high.

## Test plan
- Single write: ID 3, delay 5, address at cycle 10, response at cycle 12 -> wresp_out_valid_o first high at cycle 16 with ID 3 and the given data; occupancy goes 0→1→0.
- Fill: 8 addresses with delay 0 and no responses -> the 9th address sees waddr_in_ready_o = 0 and waddr_out_valid_o = 0. One response then release -> acceptance resumes the cycle after the release handshake.
- Same-ID ordering: ID 1 with delay 20, then ID 1 with delay 2, responses A then B -> A released first (cycle ≥ accept+21), B only after A, with B's data correct.
- Cross-ID reorder: ID 1 with delay 30, then ID 2 with delay 1, both responses early -> the ID 2 response is released before the ID 1 response.
- Stall and lock: present a release with wresp_out_ready_i = 0 for 10 cycles while an older slot becomes releasable -> ID and data unchanged until the handshake, then the older slot follows.
- Unmatched response ID 7 with no outstanding ID 7 -> wresp_in_ready_o = 0. Then issue address ID 7 -> response accepted the cycle after. Assert reset mid-traffic -> all outputs take their reset values immediately.
